// File: rtl/lcd_time_writer.sv
// lcd_time_writer: initialises an HD44780-style character LCD over an 8-bit
// write-only bus, then repeatedly writes "HH:MM:SS.cc" to line 1, columns 0-10.
// Every frame uses a snapshot of the eight digit inputs taken when that frame
// starts.
//
// Bus handshake: there is no ready signal. Each bus transaction takes three
// ticks. On the first tick lcd_rs and lcd_data are driven while lcd_e stays 0.
// lcd_e is raised on the second tick and dropped on the third. lcd_rs and
// lcd_data then hold until the next transaction's first tick, so lcd_data is
// always stable while lcd_e is high.
module lcd_time_writer #(
    parameter int TICK_DIV      = 50,
    parameter int POWER_TICKS   = 400,
    parameter int CLEAR_TICKS   = 40,
    parameter int REFRESH_TICKS = 1000
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] cnt_1,
    input  logic [7:0] cnt_10,
    input  logic [7:0] sec_1,
    input  logic [7:0] sec_10,
    input  logic [7:0] min_1,
    input  logic [7:0] min_10,
    input  logic [7:0] hour_1,
    input  logic [7:0] hour_10,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);

    localparam int DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_PC   = (POWER_TICKS > CLEAR_TICKS) ? POWER_TICKS : CLEAR_TICKS;
    localparam int MAX_WAIT = (MAX_PC > REFRESH_TICKS) ? MAX_PC : REFRESH_TICKS;
    localparam int CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    // A wait state counts ticks and leaves on its last one. The next
    // transaction's first tick therefore follows exactly N idle ticks.
    localparam logic [CNT_W-1:0] POWER_LAST   = CNT_W'(POWER_TICKS - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_TICKS - 1);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_TICKS - 1);

    typedef enum logic [3:0] {
        POWER_WAIT, FUNC_SET, DISP_ON, ENTRY, CLEAR,
        CLEAR_WAIT, SET_ADDR, WRITE_CHAR, REFRESH_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_e_q, lcd_e_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;
    // snap index: 0 cnt_1, 1 cnt_10, 2 sec_1, 3 sec_10, 4 min_1, 5 min_10, 6 hour_1, 7 hour_10
    logic [7:0]       snap_q [0:7];
    logic [7:0]       snap_d [0:7];
    logic             tick;
    logic [7:0]       tx_byte;

    assign tick       = (div_q == DIV_W'(TICK_DIV - 1));
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_e      = lcd_e_q;
    assign lcd_data   = lcd_data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

    // Free-running tick divider, restarting from 0 when reset is released.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (tick) begin
            div_d = '0;
        end
    end

    // Byte that the current transaction puts on the bus: a command or a frame character.
    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            FUNC_SET: tx_byte = 8'h38;
            DISP_ON:  tx_byte = 8'h0C;
            ENTRY:    tx_byte = 8'h06;
            CLEAR:    tx_byte = 8'h01;
            SET_ADDR: tx_byte = 8'h80;
            WRITE_CHAR: begin
                case (idx_q)
                    4'd0:    tx_byte = snap_q[7];
                    4'd1:    tx_byte = snap_q[6];
                    4'd2:    tx_byte = 8'h3A;
                    4'd3:    tx_byte = snap_q[5];
                    4'd4:    tx_byte = snap_q[4];
                    4'd5:    tx_byte = 8'h3A;
                    4'd6:    tx_byte = snap_q[3];
                    4'd7:    tx_byte = snap_q[2];
                    4'd8:    tx_byte = 8'h2E;
                    4'd9:    tx_byte = snap_q[1];
                    4'd10:   tx_byte = snap_q[0];
                    default: tx_byte = 8'h00;
                endcase
            end
            default: tx_byte = 8'h00;
        endcase
    end

    // Sequencer: wait states count ticks, and command or data states run the three-tick strobe.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_e_d      = lcd_e_q;
        lcd_data_d   = lcd_data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            snap_d[i] = snap_q[i];
        end
        if (tick) begin
            case (state_q)
                POWER_WAIT: begin
                    if (POWER_TICKS == 0 || cnt_q == POWER_LAST) begin
                        state_d = FUNC_SET;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CLEAR_WAIT: begin
                    if (cnt_q == CLEAR_LAST) begin
                        state_d     = SET_ADDR;
                        cnt_d       = '0;
                        init_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                REFRESH_WAIT: begin
                    if (cnt_q == REFRESH_LAST) begin
                        state_d = SET_ADDR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    case (phase_q)
                        2'd0: begin
                            lcd_rs_d   = (state_q == WRITE_CHAR);
                            lcd_data_d = tx_byte;
                            lcd_e_d    = 1'b0;
                            phase_d    = 2'd1;
                            if (state_q == SET_ADDR) begin
                                snap_d[0] = cnt_1;
                                snap_d[1] = cnt_10;
                                snap_d[2] = sec_1;
                                snap_d[3] = sec_10;
                                snap_d[4] = min_1;
                                snap_d[5] = min_10;
                                snap_d[6] = hour_1;
                                snap_d[7] = hour_10;
                            end
                        end
                        2'd1: begin
                            lcd_e_d = 1'b1;
                            phase_d = 2'd2;
                        end
                        default: begin
                            lcd_e_d = 1'b0;
                            phase_d = 2'd0;
                            case (state_q)
                                FUNC_SET: state_d = DISP_ON;
                                DISP_ON:  state_d = ENTRY;
                                ENTRY:    state_d = CLEAR;
                                CLEAR: begin
                                    if (CLEAR_TICKS == 0) begin
                                        state_d     = SET_ADDR;
                                        init_done_d = 1'b1;
                                    end else begin
                                        state_d = CLEAR_WAIT;
                                    end
                                end
                                SET_ADDR: begin
                                    state_d = WRITE_CHAR;
                                    idx_d   = 4'd0;
                                end
                                WRITE_CHAR: begin
                                    if (idx_q == 4'd10) begin
                                        frame_done_d = 1'b1;
                                        idx_d        = 4'd0;
                                        if (REFRESH_TICKS == 0) begin
                                            state_d = SET_ADDR;
                                        end else begin
                                            state_d = REFRESH_WAIT;
                                        end
                                    end else begin
                                        idx_d = idx_q + 4'd1;
                                    end
                                end
                                default: state_d = POWER_WAIT;
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= POWER_WAIT;
            div_q        <= '0;
            phase_q      <= 2'd0;
            cnt_q        <= '0;
            idx_q        <= 4'd0;
            lcd_rs_q     <= 1'b0;
            lcd_e_q      <= 1'b0;
            lcd_data_q   <= 8'h00;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                snap_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_e_q      <= lcd_e_d;
            lcd_data_q   <= lcd_data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < 8; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

endmodule

// File: tb/tb_lcd_time_writer.sv
// Testbench for lcd_time_writer. A bus monitor records every lcd_e strobe.
// Each test task compares those records against a transaction-schedule model
// derived from the tick arithmetic and the frame text.
module tb_lcd_time_writer;

    localparam int TD = 2;
    localparam int PT = 4;
    localparam int CT = 3;
    localparam int RT = 5;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [7:0] cnt_1, cnt_10, sec_1, sec_10, min_1, min_10, hour_1, hour_10;
    logic       lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
    logic [7:0] lcd_data;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_time_writer #(
        .TICK_DIV(TD), .POWER_TICKS(PT), .CLEAR_TICKS(CT), .REFRESH_TICKS(RT)
    ) dut (
        .clk(clk), .nreset(nreset),
        .cnt_1(cnt_1), .cnt_10(cnt_10), .sec_1(sec_1), .sec_10(sec_10),
        .min_1(min_1), .min_10(min_10), .hour_1(hour_1), .hour_10(hour_10),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
        .init_done(init_done), .frame_done(frame_done)
    );

    // clock and cycle counter (clock number since reset release)
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge nreset) begin
        if (!nreset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // bus monitor records
    int         r_cyc[$];
    logic       r_rs[$];
    logic [7:0] r_data[$];
    logic       r_init[$];
    int         f_len[$];
    logic       f_stable[$];
    int         f_cyc[$];
    int         fd_cyc[$];
    int         ir_cyc[$];
    int         rw_bad = 0;
    logic       e_prev = 1'b0;
    logic       init_prev = 1'b0;
    int         hi_len = 0;
    logic [7:0] hi_data = 8'h00;
    logic       hi_ok = 1'b1;

    always @(negedge clk or negedge nreset) begin
        if (!nreset) begin
            if (e_prev) begin
                f_len.push_back(0);
                f_stable.push_back(1'b1);
                f_cyc.push_back(-1);
            end
            e_prev    = 1'b0;
            init_prev = 1'b0;
        end else begin
            if (lcd_rw !== 1'b0) rw_bad++;
            if (lcd_e === 1'b1 && !e_prev) begin
                r_cyc.push_back(cyc);
                r_rs.push_back(lcd_rs);
                r_data.push_back(lcd_data);
                r_init.push_back(init_done);
                hi_len  = 1;
                hi_data = lcd_data;
                hi_ok   = 1'b1;
            end else if (lcd_e === 1'b1) begin
                hi_len++;
                if (lcd_data !== hi_data) hi_ok = 1'b0;
            end else if (e_prev) begin
                f_len.push_back(hi_len);
                f_stable.push_back(hi_ok);
                f_cyc.push_back(cyc);
            end
            if (frame_done === 1'b1) fd_cyc.push_back(cyc);
            if (init_done === 1'b1 && !init_prev) ir_cyc.push_back(cyc);
            e_prev    = (lcd_e === 1'b1);
            init_prev = (init_done === 1'b1);
        end
    end

    // input history of the current run: values applied and the clock they were set after
    logic [63:0] hist_v[$];
    int          hist_c[$];
    logic [63:0] cur_dg;
    int run_base, f_base, fd_base, ir_base;

    // expected-value scoreboard for the transaction being compared
    logic [8:0] exp_q[$];

    task automatic set_inputs(input logic [63:0] dg);
        cur_dg = dg;
        {hour_10, hour_1, min_10, min_1, sec_10, sec_1, cnt_10, cnt_1} = dg;
        hist_v.push_back(dg);
        hist_c.push_back(cyc);
    endtask

    task automatic start_run();
        hist_v.delete();
        hist_c.delete();
        hist_v.push_back(cur_dg);
        hist_c.push_back(0);
        run_base = r_cyc.size();
        f_base   = f_len.size();
        fd_base  = fd_cyc.size();
        ir_base  = ir_cyc.size();
    endtask

    task automatic wait_count(input bit falls, input int n, output bit ok);
        int guard = 0;
        while (((falls ? (f_len.size() - f_base) : (r_cyc.size() - run_base)) < n) && guard < 4000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        ok = ((falls ? (f_len.size() - f_base) : (r_cyc.size() - run_base)) >= n);
    endtask

    // ---- reference model: schedule of transactions counted from reset release ----
    function automatic int model_start(input int k);
        int j;
        if (k < 4) return PT + 1 + 3 * k;
        j = k - 4;
        return PT + 1 + 12 + CT + (j / 12) * (36 + RT) + 3 * (j % 12);
    endfunction

    function automatic logic [63:0] digits_at(input int latch_clk);
        logic [63:0] v = hist_v[0];
        for (int i = 0; i < hist_v.size(); i++) begin
            if (hist_c[i] < latch_clk) v = hist_v[i];
        end
        return v;
    endfunction

    // {rs, byte} of transaction k; the frame text is "HH:MM:SS.cc"
    function automatic logic [8:0] model_byte(input int k);
        int j, p;
        logic [63:0] dg;
        logic [7:0] c;
        if (k == 0) return {1'b0, 8'h38};
        if (k == 1) return {1'b0, 8'h0C};
        if (k == 2) return {1'b0, 8'h06};
        if (k == 3) return {1'b0, 8'h01};
        j = k - 4;
        if (j % 12 == 0) return {1'b0, 8'h80};
        dg = digits_at(TD * model_start(k - j % 12));
        p = j % 12 - 1;
        case (p)
            0: c = dg[63:56];
            1: c = dg[55:48];
            2: c = 8'h3A;
            3: c = dg[47:40];
            4: c = dg[39:32];
            5: c = 8'h3A;
            6: c = dg[31:24];
            7: c = dg[23:16];
            8: c = 8'h2E;
            9: c = dg[15:8];
            default: c = dg[7:0];
        endcase
        return {1'b1, c};
    endfunction

    // ---- tests ----
    task automatic test_reset();
        nreset = 1'b0;
        set_inputs(64'h3132_3334_3536_3738);
        start_run();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (lcd_rs !== 1'b0)     begin n_fail++; $display("FAIL reset_rs got %b want 0", lcd_rs); end
        n_checks++; if (lcd_rw !== 1'b0)     begin n_fail++; $display("FAIL reset_rw got %b want 0", lcd_rw); end
        n_checks++; if (lcd_e !== 1'b0)      begin n_fail++; $display("FAIL reset_e got %b want 0", lcd_e); end
        n_checks++; if (lcd_data !== 8'h00)  begin n_fail++; $display("FAIL reset_data got %h want 00", lcd_data); end
        n_checks++; if (init_done !== 1'b0)  begin n_fail++; $display("FAIL reset_init got %b want 0", init_done); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b want 0", frame_done); end
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_power_up();
        bit ok;
        wait_count(1'b1, 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL power_up_timeout got no strobe want one"); return; end
        n_checks++;
        if (r_cyc[run_base] < TD * (PT + 1)) begin
            n_fail++; $display("FAIL power_up_early got rise at clk %0d want >= %0d", r_cyc[run_base], TD * (PT + 1));
        end
        n_checks++;
        if ({r_rs[run_base], r_data[run_base]} !== {1'b0, 8'h38}) begin
            n_fail++; $display("FAIL power_up_first got rs=%b data=%h want rs=0 data=38", r_rs[run_base], r_data[run_base]);
        end
    endtask

    task automatic test_init_seq();
        bit ok;
        wait_count(1'b1, 5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL init_timeout got fewer than 5 strobes want 5"); return; end
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(model_byte(k));
            n_checks++;
            if ({r_rs[run_base+k], r_data[run_base+k]} !== exp_q[0]) begin
                n_fail++; $display("FAIL init_byte[%0d] got %h want %h", k, {r_rs[run_base+k], r_data[run_base+k]}, exp_q[0]);
            end
            void'(exp_q.pop_front());
            n_checks++;
            if (r_cyc[run_base+k] !== TD * (model_start(k) + 1)) begin
                n_fail++; $display("FAIL init_rise_time[%0d] got %0d want %0d", k, r_cyc[run_base+k], TD * (model_start(k) + 1));
            end
            n_checks++;
            if (f_len[f_base+k] !== TD || f_stable[f_base+k] !== 1'b1) begin
                n_fail++; $display("FAIL init_strobe[%0d] got len=%0d stable=%b want len=%0d stable=1", k, f_len[f_base+k], f_stable[f_base+k], TD);
            end
        end
        n_checks++;
        if (r_cyc[run_base+4] - f_cyc[f_base+3] !== TD * (CT + 2)) begin
            n_fail++; $display("FAIL clear_gap got %0d clks want %0d", r_cyc[run_base+4] - f_cyc[f_base+3], TD * (CT + 2));
        end
        n_checks++;
        if (r_init[run_base+3] !== 1'b0 || r_init[run_base+4] !== 1'b1) begin
            n_fail++; $display("FAIL init_done_order got at01=%b at80=%b want 0 1", r_init[run_base+3], r_init[run_base+4]);
        end
        n_checks++;
        if (ir_cyc.size() - ir_base !== 1 || ir_cyc[ir_base] !== TD * (model_start(4) - 1)) begin
            n_fail++; $display("FAIL init_done_rise got %0d rises want one at clk %0d", ir_cyc.size() - ir_base, TD * (model_start(4) - 1));
        end
    endtask

    task automatic test_frame_content();
        bit ok;
        logic [87:0] text = "12:34:56.78";
        wait_count(1'b1, 16, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL frame_timeout got fewer than 16 strobes want 16"); return; end
        for (int k = 5; k < 16; k++) begin
            exp_q.push_back({1'b1, text[8*(15-k) +: 8]});
            n_checks++;
            if ({r_rs[run_base+k], r_data[run_base+k]} !== exp_q[0]) begin
                n_fail++; $display("FAIL frame_char[%0d] got %h want %h", k - 5, {r_rs[run_base+k], r_data[run_base+k]}, exp_q[0]);
            end
            void'(exp_q.pop_front());
            n_checks++;
            if (r_cyc[run_base+k] !== TD * (model_start(k) + 1) || f_len[f_base+k] !== TD || f_stable[f_base+k] !== 1'b1) begin
                n_fail++; $display("FAIL frame_strobe[%0d] got rise=%0d len=%0d stable=%b want rise=%0d len=%0d stable=1",
                                   k - 5, r_cyc[run_base+k], f_len[f_base+k], f_stable[f_base+k], TD * (model_start(k) + 1), TD);
            end
        end
        n_checks++;
        if (fd_cyc.size() - fd_base !== 1 || fd_cyc[fd_base] !== TD * (model_start(15) + 2)) begin
            n_fail++; $display("FAIL frame_done got %0d pulses want one at clk %0d", fd_cyc.size() - fd_base, TD * (model_start(15) + 2));
        end
    endtask

    task automatic test_snapshot();
        bit ok;
        logic [63:0] dg;
        wait_count(1'b0, 21, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL snap_timeout got no 4th char want one"); return; end
        dg = cur_dg;
        dg[23:16] = 8'h39;
        set_inputs(dg);
        wait_count(1'b1, 40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL snap_frames_timeout got fewer than 40 strobes want 40"); return; end
        n_checks++;
        if (r_data[run_base+24] !== 8'h36) begin
            n_fail++; $display("FAIL snap_current got %h want 36", r_data[run_base+24]);
        end
        n_checks++;
        if (r_data[run_base+36] !== 8'h39) begin
            n_fail++; $display("FAIL snap_next got %h want 39", r_data[run_base+36]);
        end
        n_checks++;
        if (r_data[run_base+28] !== 8'h80 || r_cyc[run_base+28] - f_cyc[f_base+27] !== TD * (RT + 2)) begin
            n_fail++; $display("FAIL refresh_gap got data=%h gap=%0d want data=80 gap=%0d", r_data[run_base+28], r_cyc[run_base+28] - f_cyc[f_base+27], TD * (RT + 2));
        end
        for (int k = 16; k < 40; k++) begin
            n_checks++;
            if ({r_rs[run_base+k], r_data[run_base+k]} !== model_byte(k) || r_cyc[run_base+k] !== TD * (model_start(k) + 1)) begin
                n_fail++; $display("FAIL snap_txn[%0d] got %h@%0d want %h@%0d", k, {r_rs[run_base+k], r_data[run_base+k]}, r_cyc[run_base+k], model_byte(k), TD * (model_start(k) + 1));
            end
        end
        n_checks++;
        if (fd_cyc.size() - fd_base !== 3) begin
            n_fail++; $display("FAIL snap_fd_count got %0d want 3", fd_cyc.size() - fd_base);
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        logic [63:0] dg;
        for (int f = 3; f < 6; f++) begin
            wait_count(1'b0, 4 + 12 * f + int'($urandom_range(0, 11)) + 1, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_timeout got stall in frame %0d want progress", f); return; end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 3) == 0) dg[8*b +: 8] = 8'($urandom_range(0, 255));
                else                           dg[8*b +: 8] = 8'h30 + 8'($urandom_range(0, 9));
            end
            if (f == 3) dg[7:0] = 8'h00;
            set_inputs(dg);
        end
        wait_count(1'b1, 76, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_frames_timeout got fewer than 76 strobes want 76"); return; end
        for (int k = 40; k < 76; k++) begin
            n_checks++;
            if ({r_rs[run_base+k], r_data[run_base+k]} !== model_byte(k) || r_cyc[run_base+k] !== TD * (model_start(k) + 1)
                || f_len[f_base+k] !== TD || f_stable[f_base+k] !== 1'b1) begin
                n_fail++; $display("FAIL rand_txn[%0d] got %h@%0d len=%0d want %h@%0d len=%0d", k, {r_rs[run_base+k], r_data[run_base+k]},
                                   r_cyc[run_base+k], f_len[f_base+k], model_byte(k), TD * (model_start(k) + 1), TD);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        wait_count(1'b0, 83, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_timeout got no 6th char want one"); return; end
        nreset = 1'b0;
        #1;
        n_checks++;
        if ({lcd_e, lcd_rs, lcd_data, init_done, frame_done} !== 12'h000) begin
            n_fail++; $display("FAIL midrst_clear got e=%b rs=%b data=%h init=%b fd=%b want all 0", lcd_e, lcd_rs, lcd_data, init_done, frame_done);
        end
        start_run();
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (fd_cyc.size() - fd_base !== 0 || init_done !== 1'b0) begin
            n_fail++; $display("FAIL midrst_hold got fd=%0d init=%b want fd=0 init=0", fd_cyc.size() - fd_base, init_done);
        end
        nreset = 1'b1;
        wait_count(1'b1, 16, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_restart_timeout got fewer than 16 strobes want 16"); return; end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if ({r_rs[run_base+k], r_data[run_base+k]} !== model_byte(k) || r_cyc[run_base+k] !== TD * (model_start(k) + 1)
                || r_init[run_base+k] !== (k >= 4)) begin
                n_fail++; $display("FAIL midrst_txn[%0d] got %h@%0d init=%b want %h@%0d init=%b", k, {r_rs[run_base+k], r_data[run_base+k]},
                                   r_cyc[run_base+k], r_init[run_base+k], model_byte(k), TD * (model_start(k) + 1), (k >= 4));
            end
        end
        n_checks++;
        if (fd_cyc.size() - fd_base !== 1 || fd_cyc[fd_base] !== TD * (model_start(15) + 2)) begin
            n_fail++; $display("FAIL midrst_fd got %0d pulses want one at clk %0d", fd_cyc.size() - fd_base, TD * (model_start(15) + 2));
        end
    endtask

    task automatic test_timing_invariants();
        n_checks++;
        if (rw_bad !== 0) begin
            n_fail++; $display("FAIL rw_low got %0d high samples want 0", rw_bad);
        end
    endtask

    // single sequential test flow, then report
    initial begin
        test_reset();
        test_power_up();
        test_init_seq();
        test_frame_content();
        test_snapshot();
        test_random_frames();
        test_mid_reset();
        test_timing_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
